// File: rtl/g726_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : g726_pkg
//  Purpose  : Shared constants and FSM state type for the G.726 UPA2 stage.
//  Revision : 1.0
// ============================================================================
package g726_pkg;

    localparam logic [16:0] c_UGA2A_NEG   = 17'd114688;
    localparam logic [16:0] c_UGA2A_POS   = 17'd16384;
    localparam logic [15:0] c_A1_NEG_LIM  = 16'd57345;
    localparam logic [16:0] c_A1S_NEG_SAT = 17'd98308;
    localparam logic [15:0] c_A1_POS_LIM  = 16'd8191;
    localparam logic [16:0] c_A1S_POS_SAT = 17'd32764;
    localparam logic [16:0] c_UGA2_SEXT   = 17'd126976;
    localparam logic [16:0] c_ULA2_SEXT   = 17'd65024;
    localparam logic [15:0] c_A2UL        = 16'd12288;
    localparam logic [15:0] c_A2LL        = 16'd53248;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } upa2_state_t;

endpackage
`default_nettype wire

// File: rtl/upa2_hist.sv
`default_nettype none
// ============================================================================
//  Module   : upa2_hist
//  Purpose  : Per-channel PK1/PK2 sign history, combinational read, shift on write.
//  Revision : 1.0
// ============================================================================
module upa2_hist #(
    parameter int CHANNELS = 32,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH_W-1:0] i_ch,
    input  logic            i_we,
    input  logic            i_pk0,
    output logic            o_pk1,
    output logic            o_pk2
);

    logic [CHANNELS-1:0] w_pk1;
    logic [CHANNELS-1:0] w_pk2;
    logic                w_ch_ok;

    // Out-of-range channels read as zero history and are never written.
    assign w_ch_ok = (32'(i_ch) < 32'(CHANNELS));

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_entry
            logic r_pk1;
            logic r_pk2;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_pk1 <= 1'b0;
                    r_pk2 <= 1'b0;
                end else if (i_we && w_ch_ok && (32'(i_ch) == 32'(i))) begin
                    r_pk2 <= r_pk1;
                    r_pk1 <= i_pk0;
                end
            end

            assign w_pk1[i] = r_pk1;
            assign w_pk2[i] = r_pk2;
        end
    endgenerate

    assign o_pk1 = w_ch_ok ? w_pk1[i_ch] : 1'b0;
    assign o_pk2 = w_ch_ok ? w_pk2[i_ch] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/upa2.sv
`default_nettype none
// ============================================================================
//  Module   : upa2
//  Purpose  : G.726 second-order pole coefficient (A2) update, time-shared
//             over CHANNELS with a start/done handshake.
//  Options  : UPA2_LIMC_EN clamps A2T to [-12288, 12288] before registering.
//  Revision : 1.0
// ============================================================================
module upa2
    import g726_pkg::*;
#(
    parameter int CHANNELS = 32,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CH_W-1:0] ch,
    input  logic            pk0,
    input  logic            sigpk,
    input  logic            tr,
    input  logic [15:0]     a1,
    input  logic [15:0]     a2,
    output logic            ready,
    output logic            done,
    output logic [15:0]     a2p
);

    upa2_state_t     r_state, w_next;
    logic [CH_W-1:0] r_ch;
    logic            r_pk0, r_sigpk, r_tr;
    logic [15:0]     r_a1, r_a2;
    logic            r_pk1, r_pk2;
    logic [15:0]     r_a2t, r_a2p;
    logic            r_done;
    logic            w_rd_pk1, w_rd_pk2, w_hist_we;

    logic            w_pks1, w_pks2;
    logic [16:0]     w_uga2a, w_a1s, w_fa, w_uga2b, w_uga2b_sh, w_uga2;
    logic [16:0]     w_a2_sh, w_ula2, w_ua2_sum;
    logic [15:0]     w_a2t, w_lim, w_result;

    upa2_hist #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_hist (
        .clk   (clk),
        .reset (reset),
        .i_ch  (r_ch),
        .i_we  (w_hist_we),
        .i_pk0 (r_pk0),
        .o_pk1 (w_rd_pk1),
        .o_pk2 (w_rd_pk2)
    );

    always_comb begin
        w_next    = r_state;
        w_hist_we = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_FETCH;
            ST_FETCH: w_next = ST_CALC;
            ST_CALC: begin
                w_next    = ST_DONE;
                w_hist_we = 1'b1;
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pks1  = r_pk0 ^ r_pk1;
        w_pks2  = r_pk0 ^ r_pk2;
        w_uga2a = w_pks2 ? c_UGA2A_NEG : c_UGA2A_POS;
        if (r_a1[15])
            w_a1s = (r_a1 >= c_A1_NEG_LIM) ? {r_a1[14:0], 2'b00} : c_A1S_NEG_SAT;
        else
            w_a1s = (r_a1 <= c_A1_POS_LIM) ? {r_a1[14:0], 2'b00} : c_A1S_POS_SAT;
        w_fa       = w_pks1 ? w_a1s : (17'd0 - w_a1s);
        w_uga2b    = w_uga2a + w_fa;
        w_uga2b_sh = w_uga2b >> 7;
        // Bit 16 is the sign of UGA2B; extend it across the shifted-out range.
        if (r_sigpk)
            w_uga2 = 17'd0;
        else
            w_uga2 = w_uga2b[16] ? (w_uga2b_sh + c_UGA2_SEXT) : w_uga2b_sh;
        w_a2_sh   = {1'b0, r_a2} >> 7;
        w_ula2    = r_a2[15] ? (17'd65536 - (w_a2_sh + c_ULA2_SEXT))
                             : (17'd65536 - w_a2_sh);
        w_ua2_sum = w_uga2 + w_ula2;
        w_a2t     = r_a2 + w_ua2_sum[15:0];
`ifdef UPA2_LIMC_EN
        if ($signed(w_a2t) > $signed(c_A2UL))
            w_lim = c_A2UL;
        else if ($signed(w_a2t) < $signed(c_A2LL))
            w_lim = c_A2LL;
        else
            w_lim = w_a2t;
`else
        w_lim = w_a2t;
`endif
        w_result = r_tr ? 16'd0 : w_lim;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ch    <= '0;
            r_pk0   <= 1'b0;
            r_sigpk <= 1'b0;
            r_tr    <= 1'b0;
            r_a1    <= 16'd0;
            r_a2    <= 16'd0;
            r_pk1   <= 1'b0;
            r_pk2   <= 1'b0;
            r_a2t   <= 16'd0;
            r_a2p   <= 16'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ch    <= ch;
                        r_pk0   <= pk0;
                        r_sigpk <= sigpk;
                        r_tr    <= tr;
                        r_a1    <= a1;
                        r_a2    <= a2;
                    end
                end
                ST_FETCH: begin
                    r_pk1 <= w_rd_pk1;
                    r_pk2 <= w_rd_pk2;
                end
                ST_CALC:  r_a2t <= w_result;
                default:  r_a2p <= r_a2t;
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = r_done;
    assign a2p   = r_a2p;

endmodule
`default_nettype wire

// File: tb/tb_upa2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_upa2
//  Purpose  : Self-checking bench for upa2 against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
module tb_upa2;

    localparam int CHANNELS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  ch = 5'd0;
    logic        pk0 = 1'b0, sigpk = 1'b0, tr = 1'b0;
    logic [15:0] a1 = 16'd0, a2 = 16'd0;
    logic        ready, done;
    logic [15:0] a2p;

    int checks = 0;
    int errors = 0;
    int m_pk1[CHANNELS];
    int m_pk2[CHANNELS];

    always #5 clk = ~clk;

    upa2 #(.CHANNELS(CHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ch    (ch),
        .pk0   (pk0),
        .sigpk (sigpk),
        .tr    (tr),
        .a1    (a1),
        .a2    (a2),
        .ready (ready),
        .done  (done),
        .a2p   (a2p)
    );

    function automatic int ref_a2p(int p, int k1, int k2, int s, int t, int x1, int x2);
        int a1s, fa, uga2a, uga2b, uga2, ula2, ua2, a2t, sv;
        uga2a = ((p ^ k2) != 0) ? 114688 : 16384;
        if (x1 >= 32768) a1s = (x1 >= 57345) ? (x1 * 4) % 131072 : 98308;
        else             a1s = (x1 <= 8191) ? x1 * 4 : 32764;
        fa    = ((p ^ k1) != 0) ? a1s : (131072 - a1s) % 131072;
        uga2b = (uga2a + fa) % 131072;
        if (s != 0)              uga2 = 0;
        else if (uga2b >= 65536) uga2 = uga2b / 128 + 126976;
        else                     uga2 = uga2b / 128;
        ula2 = (x2 >= 32768) ? 65536 - (x2 / 128 + 65024) : 65536 - x2 / 128;
        ua2  = (uga2 + ula2) % 65536;
        a2t  = (x2 + ua2) % 65536;
`ifdef UPA2_LIMC_EN
        sv = (a2t >= 32768) ? a2t - 65536 : a2t;
        if (sv > 12288)  sv = 12288;
        if (sv < -12288) sv = -12288;
        a2t = (sv < 0) ? sv + 65536 : sv;
`else
        sv = a2t;
`endif
        return (t != 0) ? 0 : a2t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One request; checks handshake timing and the result against the model.
    task automatic run_req(input logic [4:0] c, input logic p, input logic s, input logic t,
                           input logic [15:0] x1, input logic [15:0] x2, input bit hold,
                           input string tag);
        int exp;
        int budget;
        budget = 0;
        @(negedge clk);
        while (ready !== 1'b1 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check({tag, "_ready"}, 32'(ready), 32'd1);
        ch = c; pk0 = p; sigpk = s; tr = t; a1 = x1; a2 = x2; start = 1'b1;
        exp = ref_a2p(int'(p), m_pk1[c], m_pk2[c], int'(s), int'(t), int'(x1), int'(x2));
        m_pk2[c] = m_pk1[c];
        m_pk1[c] = int'(p);
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            ch = 5'($urandom); pk0 = 1'($urandom); sigpk = 1'($urandom);
            tr = 1'($urandom); a1 = 16'($urandom); a2 = 16'($urandom);
        end
        check({tag, "_busy"}, 32'(ready), 32'd0);
        check({tag, "_done_t1"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_t2"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_t3"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_a2p"}, 32'(a2p), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [15:0] ra1, ra2;
        for (int i = 0; i < CHANNELS; i++) begin
            m_pk1[i] = 0;
            m_pk2[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_a2p", 32'(a2p), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_req(5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, "zero");
        check("zero_lit", 32'(a2p), 32'd128);
        run_req(5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, "follow");
        check("follow_lit", 32'(a2p), 32'd62336);
        run_req(5'd1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, "sigpk");
        check("sigpk_lit", 32'(a2p), 32'd0);
        run_req(5'd2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd16384, 1'b0, "clamp");
`ifdef UPA2_LIMC_EN
        check("clamp_lit", 32'(a2p), 32'd12288);
`else
        check("clamp_lit", 32'(a2p), 32'd16384);
`endif
        run_req(5'd3, 1'b1, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, "tr");
        check("tr_lit", 32'(a2p), 32'd0);
        run_req(5'd3, 1'b0, 1'b0, 1'b0, 16'd100, 16'd0, 1'b0, "after_tr");
        check("after_tr_lit", 32'(a2p), 32'd131);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ra1 = 16'($urandom_range(57340, 57350));
                1:       ra1 = 16'($urandom_range(8186, 8196));
                default: ra1 = 16'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       ra2 = 16'($urandom_range(12200, 16500));
                1:       ra2 = 16'($urandom_range(49000, 53300));
                default: ra2 = 16'($urandom);
            endcase
            run_req(5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 9) == 0), ra1, ra2, 1'($urandom), "rand");
        end

        run_req(5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, "prep1");
        run_req(5'd0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, "prep2");
        @(negedge clk);
        ch = 5'd0; pk0 = 1'b1; sigpk = 1'b0; tr = 1'b0; a1 = 16'd0; a2 = 16'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_a2p", 32'(a2p), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            m_pk1[i] = 0;
            m_pk2[i] = 0;
        end
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen++;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        run_req(5'd0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, "post_rst");
        check("post_rst_lit", 32'(a2p), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
